p_div_pow2_arb: RTL
===================

// Module: p_div_pow2_arb
// PURPOSE
//  Shares one power-of-2 divider (INT/FXP shift with selectable carry-up) among NREQ requesters,
//  e.g. the neuron-sum normalisation stage of several perceptron lanes.
//  Round-robin arbiter feeds the divider; the result is registered in a one-entry output buffer.
//  The buffer carries the requester id. Valid/ready on both sides.
// PARAMETERS
//  NREQ     4           number of requesters (>=2)
//  SHIFT    2           divide by 1<<SHIFT (>=1)
//  CARRYUP  0           0: truncate; 1: +1 if rem >= 1<<(SHIFT-1); 2: +1 if rem != 0
//  I_CONF   `DEF_DCONF  input data config (dtype INT or FXP; prec = input width)
//  O_CONF   `DEF_DCONF  output data config (O_CONF.prec = output width)
//  IDW      $clog2(NREQ) requester id width (derived, not overridable)
// PORTS
//  clk        in   1                  clock, rising edge
//  reset_     in   1                  asynchronous reset, active low
//  req_valid  in   NREQ               per-requester request valid
//  req_ready  out  NREQ               per-requester accept; one-hot or zero
//  req_data   in   NREQ*I_CONF.prec   packed dividends; requester k at [k*prec +: prec]
//  out_valid  out  1                  result valid
//  out_ready  in   1                  downstream accepts result
//  out_data   out  O_CONF.prec        quotient after carry-up
//  out_rem    out  SHIFT              discarded low bits (in[SHIFT-1:0])
//  out_id     out  IDW                index of the requester that produced out_data
//  busy       out  1                  out_valid | (|req_valid)
// BEHAVIOUR
//  Reset (async assert, sync-released use): out_valid=0; out_data, out_rem, out_id = 0;
//   req_ready=0; rr pointer=0.
//  Datapath: one shared combinational divider, driven by the granted req_data.
//   Signed arithmetic shift right by SHIFT. Carry-up per CARRYUP.
//   Result is sign-extended or truncated to O_CONF.prec.
//   BOOL and FP dtypes are unsupported: elaboration-time $error.
//  States:
//   EMPTY (out_valid=0) -> FULL on any grant.
//   FULL -> FULL when out_ready & grant (back-to-back).
//   FULL -> EMPTY when out_ready & no grant.
//   FULL & !out_ready -> stays FULL; no grant.
//  can_accept = !out_valid | out_ready (same-cycle drain+refill allowed; throughput 1/cycle).
//  Arbitration:
//   - grant = first k with req_valid[k], searching ptr, ptr+1, ... mod NREQ.
//   - req_ready[k] = can_accept & grant[k].
//   - Handshake on req_valid[k] & req_ready[k].
//   - req_ready depends on req_valid (requesters must not make valid depend on ready).
//  Pointer: after a handshake with requester k, ptr <= (k+1) mod NREQ (wraps at NREQ-1 -> 0).
//   No handshake -> ptr unchanged.
//  Latency: handshake at edge N -> out_valid, out_data, out_rem, out_id visible after edge N.
//  out_* stable while out_valid & !out_ready. out_data is never altered while held.
//  Requesters may drop req_valid without a handshake. This is not tracked and causes no error.
//  Simultaneous requests: exactly one handshake per cycle.
//   Every continuously asserting requester is served within NREQ handshakes (no starvation).
//  Reset mid-operation: the held result is discarded, out_valid drops immediately, ptr returns to 0.
//  Carry-up overflow: quotient + 1 is computed at O_CONF.prec and wraps. No saturation.
// TESTING  (INT, prec=16, SHIFT=2, NREQ=4 unless stated)
//  1. CARRYUP=0, req0 data=13, out_ready=1 -> next cycle out_data=3, rem=1, id=0; out_valid 1 cycle.
//  2. CARRYUP=1: 14 -> 4 rem 2; 13 -> 3 rem 1; -6 (0xFFFA) -> -1 (0xFFFF) rem 2.
//     CARRYUP=2: 13 -> 4 rem 1.
//  3. All 4 valid continuously, out_ready=1 -> ids 0,1,2,3,0,1...
//     One handshake per cycle; ptr wraps 3 -> 0.
//  4. out_ready=0 for 5 cycles with req1 valid (data=100) held -> out_id=1 and out_data=25 stable.
//     req_ready=0 throughout; first cycle out_ready=1 -> next result accepted the same cycle.
//  5. Only req2 valid after ptr=3 -> req2 granted (search wraps past 0,1). ptr becomes 3.
//  6. Assert reset_=0 while out_valid=1 -> out_valid=0 and outputs 0 without a clock edge.
//     After release, ptr=0 and req0 wins a tie with req3.

Source files
------------

// File: rtl/p_div_pow2_arb.sv
`default_nettype none
// ============================================================================
// Module      : p_div_pow2_arb
// Description : Round-robin arbiter sharing one power-of-2 divider (signed
//               shift right with selectable carry-up) among NREQ requesters.
//               The result, remainder and requester id are held in a
//               one-entry output buffer with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module p_div_pow2_arb #(
    parameter int NREQ    = 4,
    parameter int SHIFT   = 2,
    parameter int CARRYUP = 0,
    parameter int I_DTYPE = 0,
    parameter int I_PREC  = 16,
    parameter int O_DTYPE = 0,
    parameter int O_PREC  = 16,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*I_PREC-1:0] req_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [O_PREC-1:0]      out_data,
    output logic [SHIFT-1:0]       out_rem,
    output logic [IDW-1:0]         out_id,
    output logic                   busy
);

    // Data type encodings of the data-config dtype field.
    localparam int c_DT_INT  = 0;
    localparam int c_DT_FXP  = 1;

    // Only integer and fixed-point data can be shifted; reject the rest.
    generate
        if (!((I_DTYPE == c_DT_INT) || (I_DTYPE == c_DT_FXP)) ||
            !((O_DTYPE == c_DT_INT) || (O_DTYPE == c_DT_FXP)) ||
            (SHIFT < 1) || (SHIFT >= I_PREC) || (NREQ < 2)) begin : g_bad_config
            $error("p_div_pow2_arb: unsupported dtype or parameter combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IDW-1:0]            r_ptr;
    logic [O_PREC-1:0]         r_data;
    logic [SHIFT-1:0]          r_rem;
    logic [IDW-1:0]            r_id;

    logic                      w_gnt_any;
    logic [IDW-1:0]            w_gnt_idx;
    int                        w_k;
    logic                      w_can_accept;
    logic                      w_hs;
    logic [NREQ-1:0]           w_ready;
    logic signed [I_PREC-1:0]  w_din;
    logic signed [I_PREC-1:0]  w_shr;
    logic [SHIFT-1:0]          w_rem;
    logic [O_PREC-1:0]         w_q_ext;
    logic                      w_cu;
    logic [O_PREC-1:0]         w_q;

    // Rotating-priority search: first valid requester starting at the pointer.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_k       = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= NREQ) begin
                w_k = w_k - NREQ;
            end
            if (!w_gnt_any && req_valid[w_k[IDW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_k[IDW-1:0];
            end
        end
    end

    // Buffer can take a new result when empty or draining this cycle.
    assign w_can_accept = (r_state == ST_EMPTY) || out_ready;
    // Nothing is accepted while reset is held, even between clock edges.
    assign w_hs         = reset_ && w_gnt_any && w_can_accept;

    // One-hot ready for the granted requester only.
    always_comb begin
        w_ready = '0;
        if (w_hs) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end
    assign req_ready = w_ready;

    // Shared divider: arithmetic shift of the granted dividend.
    assign w_din = req_data[int'(w_gnt_idx)*I_PREC +: I_PREC];
    assign w_shr = w_din >>> SHIFT;
    assign w_rem = w_din[SHIFT-1:0];

    generate
        if (O_PREC > I_PREC) begin : g_ext
            assign w_q_ext = {{(O_PREC-I_PREC){w_shr[I_PREC-1]}}, w_shr};
        end else begin : g_trunc
            assign w_q_ext = w_shr[O_PREC-1:0];
        end
    endgenerate

    generate
        if (CARRYUP == 1) begin : g_cu_half
            assign w_cu = w_rem[SHIFT-1];
        end else if (CARRYUP == 2) begin : g_cu_any
            assign w_cu = |w_rem;
        end else begin : g_cu_none
            assign w_cu = 1'b0;
        end
    endgenerate

    // Carry-up is added at output width and wraps on overflow.
    assign w_q = w_q_ext + {{(O_PREC-1){1'b0}}, w_cu};

    // Buffer occupancy state register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer occupancy next state: fill on grant, drain when no refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_hs) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_hs) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Result buffer and round-robin pointer, updated on each handshake.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_data <= '0;
            r_rem  <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
        end else if (w_hs) begin
            r_data <= w_q;
            r_rem  <= w_rem;
            r_id   <= w_gnt_idx;
            r_ptr  <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_rem   = r_rem;
    assign out_id    = r_id;
    assign busy      = out_valid || (|req_valid);

endmodule
`default_nettype wire
